// File: rtl/ex_mem_pkg.sv
// EX->MEM stage shared definitions: control layout and handshake state encoding.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package ex_mem_pkg;

    // Control field width and bit positions, MSB..LSB = {MemRead, MemWrite, RegWrite, MemtoReg}
    localparam int CTRL_W       = 4;
    localparam int CTL_MEMREAD  = 3;
    localparam int CTL_MEMWRITE = 2;
    localparam int CTL_REGWRITE = 1;
    localparam int CTL_MEMTOREG = 0;

    // Occupancy of the stage: nothing held, main entry held, main plus skid held
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKIDF = 2'd2
    } state_t;

endpackage

// File: rtl/ex_mem_stage_buf_slot.sv
// One valid bit plus payload register with load and clear controls.
// Latency: 1 cycle from ld to q/vld.
// Backpressure: none; the owner decides when to load or clear.
module stage_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic         vld,
    output logic [W-1:0] q
);

    // Clear wins over load; a clear drops the valid bit but leaves the payload untouched
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld <= 1'b0;
            q   <= '0;
        end else begin
            if (clr) begin
                vld <= 1'b0;
            end else if (ld) begin
                vld <= 1'b1;
            end
            if (ld && !clr) begin
                q <= d;
            end
        end
    end

endmodule

// File: rtl/ex_mem_stage_buf.sv
// EX->MEM pipeline stage: carries control, ALU result, store data and write register.
// Latency: 1 cycle input to output when MEM is not stalling.
// Backpressure: SKID=1 gives a registered in_ready via a second entry; SKID=0 gives in_ready = !out_valid || out_ready.
module ex_mem_stage_buf #(
    parameter int CTRL_W = ex_mem_pkg::CTRL_W,
    parameter int DATA_W = 32,
    parameter int WN_W   = 5,
    parameter bit SKID   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_rd2,
    input  logic [WN_W-1:0]   in_wn,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_alu,
    output logic [DATA_W-1:0] out_rd2,
    output logic [WN_W-1:0]   out_wn
);

    import ex_mem_pkg::*;

    localparam int PW = CTRL_W + 2 * DATA_W + WN_W;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] rd2;
        logic [WN_W-1:0]   wn;
    } pay_t;

    state_t state;
    state_t nxt;
    logic   in_ready_q;
    logic   in_xfer;
    logic   out_xfer;
    logic   main_vld;
    logic   main_ld;
    logic   main_clr;
    logic   skid_vld;
    logic   skid_ld;
    logic   skid_clr;
    pay_t   in_pay;
    pay_t   main_d;
    pay_t   main_q;
    pay_t   skid_q;

    assign in_pay   = '{ctrl: in_ctrl, alu: in_alu, rd2: in_rd2, wn: in_wn};
    assign in_ready = SKID ? in_ready_q : (!main_vld || out_ready);
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = main_vld && out_ready;

    stage_slot #(.W(PW)) u_main (
        .clk (clk),
        .rst (rst),
        .ld  (main_ld),
        .clr (main_clr),
        .d   (main_d),
        .vld (main_vld),
        .q   (main_q)
    );

    generate
        if (SKID) begin : g_skid
            stage_slot #(.W(PW)) u_skid (
                .clk (clk),
                .rst (rst),
                .ld  (skid_ld),
                .clr (skid_clr),
                .d   (in_pay),
                .vld (skid_vld),
                .q   (skid_q)
            );
        end else begin : g_noskid
            assign skid_vld = 1'b0;
            assign skid_q   = '0;
        end
    endgenerate

    // Occupancy state and the registered ready it implies (low only while both entries are held)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state      <= nxt;
            in_ready_q <= (nxt != ST_SKIDF);
        end
    end

    // Next occupancy and slot load/clear strobes; flush discards everything including this cycle's input
    always_comb begin
        nxt      = state;
        main_ld  = 1'b0;
        main_clr = 1'b0;
        main_d   = in_pay;
        skid_ld  = 1'b0;
        skid_clr = 1'b0;
        if (flush) begin
            nxt      = ST_EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else if (!SKID) begin
            if (in_xfer) begin
                main_ld = 1'b1;
                nxt     = ST_FULL;
            end else if (out_xfer) begin
                main_clr = 1'b1;
                nxt      = ST_EMPTY;
            end
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        main_ld = 1'b1;
                        nxt     = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (in_xfer && out_xfer) begin
                        main_ld = 1'b1;
                    end else if (in_xfer) begin
                        skid_ld = 1'b1;
                        nxt     = ST_SKIDF;
                    end else if (out_xfer) begin
                        main_clr = 1'b1;
                        nxt      = ST_EMPTY;
                    end
                end
                ST_SKIDF: begin
                    if (out_xfer) begin
                        main_ld  = 1'b1;
                        main_d   = skid_q;
                        skid_clr = 1'b1;
                        nxt      = ST_FULL;
                    end
                end
                default: begin
                    nxt = ST_EMPTY;
                end
            endcase
        end
    end

    // Bubbles never carry live control bits; data fields just keep their last value
    always_comb begin
        out_valid = main_vld;
        out_ctrl  = main_vld ? main_q.ctrl : '0;
        out_alu   = main_q.alu;
        out_rd2   = main_q.rd2;
        out_wn    = main_q.wn;
    end

endmodule
